// File: rtl/core_rvfi_checker.sv
// rtl/core_rvfi_checker.sv - RVFI retirement stream consistency checker (NRET=1)
// Checks order, PC continuity, x0 writes and source operands against a shadow regfile.
module core_rvfi_checker #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [ILEN-1:0] rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_intr,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic            chk_error,
  output logic [2:0]      chk_code,
  output logic [63:0]     chk_err_order,
  output logic [63:0]     chk_retired
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state;
  logic [63:0]     exp_order;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] shadow [32];
  logic [31:0]     shadow_vld;

  logic            order_bad, pc_bad, x0_bad, rs1_bad, rs2_bad;
  logic [2:0]      viol_code;
  logic            accept, learn;
  logic            unused_insn;

  assign unused_insn = ^rvfi_insn;

  // Order and PC continuity only make sense once an anchor retirement has been seen.
  assign order_bad = (state == RUN) && (rvfi_order != exp_order);
  assign pc_bad    = (state == RUN) && !rvfi_intr && (rvfi_pc_rdata != exp_pc);
  assign x0_bad    = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
  assign rs1_bad   = !rvfi_trap && ((rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != '0) :
                     (shadow_vld[rvfi_rs1_addr] && (rvfi_rs1_rdata != shadow[rvfi_rs1_addr])));
  assign rs2_bad   = !rvfi_trap && ((rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != '0) :
                     (shadow_vld[rvfi_rs2_addr] && (rvfi_rs2_rdata != shadow[rvfi_rs2_addr])));

  always_comb begin
    viol_code = 3'd0;
    if (order_bad)     viol_code = 3'd1;
    else if (pc_bad)   viol_code = 3'd2;
    else if (x0_bad)   viol_code = 3'd3;
    else if (rs1_bad)  viol_code = 3'd4;
    else if (rs2_bad)  viol_code = 3'd5;
  end

  assign accept = rvfi_valid && (state != HALT) && (viol_code == 3'd0);
  assign learn  = accept && !rvfi_trap && (rvfi_rd_addr != 5'd0);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state         <= IDLE;
      chk_error     <= 1'b0;
      chk_code      <= 3'd0;
      chk_err_order <= 64'd0;
      chk_retired   <= 64'd0;
      exp_order     <= 64'd0;
      exp_pc        <= '0;
      shadow_vld    <= 32'd0;
    end else if (rvfi_valid && (state != HALT)) begin
      if (viol_code != 3'd0) begin
        state         <= HALT;
        chk_error     <= 1'b1;
        chk_code      <= viol_code;
        chk_err_order <= rvfi_order;
      end else begin
        state       <= RUN;
        exp_order   <= rvfi_order + 64'd1;
        exp_pc      <= rvfi_pc_wdata;
        chk_retired <= chk_retired + 64'd1;
        if (learn) shadow_vld[rvfi_rd_addr] <= 1'b1;
      end
    end
  end

  // Data array needs no reset: its valid bits gate every use.
  always_ff @(posedge g_clk) begin
    if (!g_reset && learn) shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

endmodule

// File: tb/tb_core_rvfi_checker.sv
// tb/tb_core_rvfi_checker.sv - self-checking bench for core_rvfi_checker
module tb_core_rvfi_checker;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic        rvfi_trap = 1'b0, rvfi_intr = 1'b0;
  logic [4:0]  rvfi_rs1_addr = '0, rvfi_rs2_addr = '0, rvfi_rd_addr = '0;
  logic [31:0] rvfi_rs1_rdata = '0, rvfi_rs2_rdata = '0, rvfi_rd_wdata = '0;
  logic [31:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
  logic        chk_error;
  logic [2:0]  chk_code;
  logic [63:0] chk_err_order, chk_retired;

  int checks = 0;
  int failures = 0;

  core_rvfi_checker #(.XLEN(32), .ILEN(32)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .chk_error(chk_error), .chk_code(chk_code), .chk_err_order(chk_err_order),
    .chk_retired(chk_retired)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    bit          rst;
    logic [63:0] order;
    logic [31:0] pc_r, pc_w;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [31:0] r1d;
    logic [4:0]  rs2;
    logic [31:0] r2d;
    bit          trap, intr;
    bit          e_err;
    logic [2:0]  e_code;
    logic [63:0] e_eord, e_ret;
  } vec_t;

  vec_t vecs[$];

  // Reference model: retirement rules applied to an associative "known register" map.
  bit          m_halt, m_started, m_err;
  logic [63:0] m_exp_order, m_eord, m_ret;
  logic [31:0] m_exp_pc;
  logic [2:0]  m_code;
  logic [31:0] m_regs [int];

  function automatic bit src_bad(logic [4:0] a, logic [31:0] d);
    if (a == 0) return d != 0;
    if (!m_regs.exists(int'(a))) return 1'b0;
    return m_regs[int'(a)] != d;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_started = 0; m_err = 0; m_code = 0; m_eord = 0; m_ret = 0;
    m_exp_order = 0; m_exp_pc = 0;
    m_regs.delete();
  endtask

  task automatic model_step(vec_t v);
    logic [2:0] c;
    if (m_halt) return;
    c = 0;
    if (m_started && v.order != m_exp_order) c = 1;
    else if (m_started && !v.intr && v.pc_r != m_exp_pc) c = 2;
    else if (v.rd == 0 && v.wd != 0) c = 3;
    else if (!v.trap && src_bad(v.rs1, v.r1d)) c = 4;
    else if (!v.trap && src_bad(v.rs2, v.r2d)) c = 5;
    if (c != 0) begin
      m_halt = 1; m_err = 1; m_code = c; m_eord = v.order;
    end else begin
      m_started = 1;
      m_exp_order = v.order + 1;
      m_exp_pc = v.pc_w;
      m_ret = m_ret + 1;
      if (!v.trap && v.rd != 0) m_regs[int'(v.rd)] = v.wd;
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_out(string tag, bit e_err, logic [2:0] e_code, logic [63:0] e_eord,
                           logic [63:0] e_ret);
    chk({tag, ".error"}, {63'd0, chk_error}, {63'd0, e_err});
    chk({tag, ".code"}, {61'd0, chk_code}, {61'd0, e_code});
    chk({tag, ".err_order"}, chk_err_order, e_eord);
    chk({tag, ".retired"}, chk_retired, e_ret);
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    model_reset();
  endtask

  task automatic drive(vec_t v);
    rvfi_order = v.order; rvfi_pc_rdata = v.pc_r; rvfi_pc_wdata = v.pc_w;
    rvfi_rd_addr = v.rd; rvfi_rd_wdata = v.wd;
    rvfi_rs1_addr = v.rs1; rvfi_rs1_rdata = v.r1d;
    rvfi_rs2_addr = v.rs2; rvfi_rs2_rdata = v.r2d;
    rvfi_trap = v.trap; rvfi_intr = v.intr;
    rvfi_insn = $urandom;
    rvfi_valid = 1'b1;
    @(posedge g_clk); #1;
    rvfi_valid = 1'b0;
  endtask

  function automatic vec_t mk(bit rst, logic [63:0] ord, logic [31:0] pr, logic [31:0] pw,
                              logic [4:0] rd, logic [31:0] wd, logic [4:0] rs1, logic [31:0] r1d,
                              logic [4:0] rs2, logic [31:0] r2d, bit trap, bit intr,
                              bit ee, logic [2:0] ec, logic [63:0] eo, logic [63:0] er);
    vec_t v;
    v.rst = rst; v.order = ord; v.pc_r = pr; v.pc_w = pw; v.rd = rd; v.wd = wd;
    v.rs1 = rs1; v.r1d = r1d; v.rs2 = rs2; v.r2d = r2d; v.trap = trap; v.intr = intr;
    v.e_err = ee; v.e_code = ec; v.e_eord = eo; v.e_ret = er;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [63:0] ord;
    logic [31:0] pc;
    logic [31:0] tr [32];
    bit          tw [32];

    // rst order  pc_r         pc_w         rd wd            rs1 r1d           rs2 r2d  trap intr  err code eord ret
    vecs.push_back(mk(1, 0, 32'h80000000, 32'h80000004, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h80000004, 32'h80000008, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 2, 32'h80000008, 32'h8000000c, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3, 32'h8000000c, 32'h80000010, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2, 32'h4, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1));
    vecs.push_back(mk(0, 3, 32'h8, 32'hc, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1));
    vecs.push_back(mk(1, 5, 32'h0, 32'h4, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 6, 32'h4, 32'h8, 0, 0, 7, 32'hDEADBEEE, 0, 0, 0, 0, 1, 4, 6, 1));
    vecs.push_back(mk(1, 0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h200, 32'h204, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h200, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1));
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 3, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h4, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    // read-before-write on x5, then priority of ORDER over RS1
    vecs.push_back(mk(1, 9, 32'h0, 32'h4, 5, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 10, 32'h4, 32'h8, 5, 20, 5, 10, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 11, 32'h8, 32'hc, 0, 0, 5, 20, 5, 20, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 13, 32'hc, 32'h10, 0, 0, 5, 21, 0, 0, 0, 0, 1, 1, 13, 3));

    repeat (2) @(posedge g_clk);
    #1;
    do_reset();
    check_out("reset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i]);
      check_out($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_code, vecs[i].e_eord,
                vecs[i].e_ret);
    end

    // Reset while halted clears everything; then any order is accepted as the anchor.
    do_reset();
    check_out("halt_reset", 0, 0, 0, 0);
    drive(mk(0, 64'h1234, 32'h40, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out("post_reset", 0, 0, 0, 1);
    repeat (3) @(posedge g_clk);
    #1;
    check_out("idle_hold", 0, 0, 0, 1);

    // Randomized streams against the reference model.
    for (int s = 0; s < 30; s++) begin
      do_reset();
      ord = (s % 5 == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      pc = $urandom & 32'hFFFF_FFFC;
      for (int r = 0; r < 32; r++) begin tw[r] = 0; tr[r] = 0; end
      for (int n = 0; n < 16; n++) begin
        v.rst = 0;
        v.order = ord;
        v.intr = ($urandom_range(0, 9) == 0);
        v.pc_r = v.intr ? ($urandom & 32'hFFFF_FFFC) : pc;
        if ($urandom_range(0, 24) == 0) v.pc_r = v.pc_r + 8;
        v.pc_w = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : v.pc_r + 4;
        v.trap = ($urandom_range(0, 7) == 0);
        v.rd = 5'($urandom_range(0, 31));
        v.wd = (v.rd == 0) ? {31'd0, $urandom_range(0, 24) == 0} : $urandom;
        v.rs1 = 5'($urandom_range(0, 31));
        v.r1d = (v.rs1 == 0) ? 32'd0 : (tw[v.rs1] ? tr[v.rs1] : $urandom);
        if ($urandom_range(0, 19) == 0) v.r1d = v.r1d ^ 32'h1;
        v.rs2 = 5'($urandom_range(0, 31));
        v.r2d = (v.rs2 == 0) ? 32'd0 : (tw[v.rs2] ? tr[v.rs2] : $urandom);
        if ($urandom_range(0, 19) == 0) v.r2d = v.r2d ^ 32'h80;
        v.e_err = 0; v.e_code = 0; v.e_eord = 0; v.e_ret = 0;
        drive(v);
        model_step(v);
        check_out($sformatf("rnd%0d_%0d", s, n), m_err, m_code, m_eord, m_ret);
        if (!v.trap && v.rd != 0) begin tw[v.rd] = 1; tr[v.rd] = v.wd; end
        ord = ($urandom_range(0, 24) == 0) ? ord + 2 : ord + 1;
        pc = v.pc_w;
        if ($urandom_range(0, 5) == 0) begin @(posedge g_clk); #1; end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
